inst_encoder: RTL and testbench

- Inverse of the core's immediate generator: packs instruction fields plus a signed 32-bit immediate into a 32-bit RV32I instruction word.
- Range- and alignment-checks the immediate against the chosen format.
- Emits encoded words with an incrementing IMEM byte address over a valid/ready stream.
- Sits between the testbench/boot program loader and instruction memory; lets lab benches build programs without hand-assembled hex.

---
 rtl/inst_encoder_pkg.sv | 31 +++
 rtl/inst_pack.sv | 53 +++++
 rtl/inst_encoder.sv | 89 ++++++++
 tb/tb_inst_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared RV32I format and opcode constants plus immediate range helper, used by the encoder
// and the decoder-side blocks.
package inst_encoder_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;

  // True when v is representable as a two's-complement value of the given width.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= int'(bits) && v[i] != v[bits-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: builds the instruction word for the selected format
// and flags immediates that cannot be represented in it.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        legal
);

  always_comb begin
    inst  = 32'h0;
    legal = 1'b0;
    unique case (fmt)
      FMT_R: begin
        inst  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        inst  = {imm[11:0], rs1, funct3, rd, opcode};
        legal = sext_fits(imm, 12);
      end
      FMT_S: begin
        inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = sext_fits(imm, 12);
      end
      FMT_B: begin
        inst  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = sext_fits(imm, 13) && !imm[0];
      end
      FMT_U: begin
        inst  = {imm[31:12], rd, opcode};
        legal = (imm[11:0] == 12'h0);
      end
      FMT_J: begin
        inst  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = sext_fits(imm, 21) && !imm[0];
      end
      default: begin
        inst  = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: packs request fields into an instruction word, stamps it with the
// next IMEM byte address and offers it on a single-register valid/ready output.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_addr,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  logic [31:0] pack_inst;
  logic        pack_legal;
  logic [31:0] next_addr_q;
  logic        accept;
  logic        drain;

  inst_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .inst   (pack_inst),
    .legal  (pack_legal)
  );

  assign in_ready = !restart && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_inst    <= 32'h0;
      out_addr    <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      inst_cnt    <= '0;
      err_cnt     <= '0;
      err_sticky  <= 1'b0;
    end else if (restart) begin
      out_valid   <= 1'b0;
      out_inst    <= 32'h0;
      out_addr    <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      inst_cnt    <= '0;
      err_cnt     <= '0;
      err_sticky  <= 1'b0;
    end else begin
      if (drain && inst_cnt != '1) inst_cnt <= inst_cnt + CNT_W'(1);
      // A legal accept reloads the register even while the old word drains.
      if (accept && pack_legal) begin
        out_valid   <= 1'b1;
        out_inst    <= pack_inst;
        out_addr    <= next_addr_q;
        next_addr_q <= next_addr_q + 32'd4;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (accept && !pack_legal) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encodings, addressing, illegal immediates,
// back-pressure, async reset and restart.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [6:0]  in_opcode = 7'h0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic [15:0] inst_cnt;
  logic [15:0] err_cnt;
  logic        err_sticky;

  int tests = 0;
  int fails = 0;

  inst_encoder #(
    .BASE_ADDR (32'h0000_0000),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .inst_cnt   (inst_cnt),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = 7'd0;
    in_imm    = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request presented for exactly one edge; caller samples afterwards.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [31:0] imm);
    set_req(fmt, op, rd, rs1, rs2, f3, imm);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_inst_cnt", {16'd0, inst_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    rst = 1'b0;
    step();

    // addi x1,x0,5
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_inst", out_inst, 32'h0050_0093);
    chk("addi_addr", out_addr, 32'h0);
    step();
    chk("addi_cnt", {16'd0, inst_cnt}, 32'd1);
    chk("addi_drained", {31'd0, out_valid}, 32'd0);

    // sw x2,8(x1)
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    chk("sw_inst", out_inst, 32'h0020_a423);
    chk("sw_addr", out_addr, 32'h4);

    // beq x0,x0,-4 / jal x1,2048 / lui x5,0x12345000 back to back
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hffff_fffc);
    chk("beq_inst", out_inst, 32'hfe00_0ee3);
    chk("beq_addr", out_addr, 32'h8);
    send(3'd5, 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    chk("jal_inst", out_inst, 32'h0010_00ef);
    chk("jal_addr", out_addr, 32'hc);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    chk("lui_inst", out_inst, 32'h1234_52b7);
    chk("lui_addr", out_addr, 32'h10);
    step();
    chk("cnt_after5", {16'd0, inst_cnt}, 32'd5);

    // Illegal: misaligned branch, out-of-range I, U with low bits, fmt 7
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
    chk("badb_valid", {31'd0, out_valid}, 32'd0);
    chk("badb_err", {16'd0, err_cnt}, 32'd1);
    chk("badb_sticky", {31'd0, err_sticky}, 32'd1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    chk("badi_err", {16'd0, err_cnt}, 32'd2);
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h1234_5001);
    chk("badu_err", {16'd0, err_cnt}, 32'd3);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    chk("badfmt_err", {16'd0, err_cnt}, 32'd4);
    chk("bad_no_output", {31'd0, out_valid}, 32'd0);
    // Boundary legal: I with -2048, B with 4094
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hffff_f800);
    chk("imin_inst", out_inst, 32'h8000_0093);
    chk("imin_addr", out_addr, 32'h14);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4094);
    chk("bmax_inst", out_inst, 32'h7e00_0fe3);
    chk("bmax_addr", out_addr, 32'h18);
    step();
    chk("cnt_after7", {16'd0, inst_cnt}, 32'd7);
    chk("err_unchanged", {16'd0, err_cnt}, 32'd4);

    // Back-pressure: word A held for 5 cycles while B waits
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1);
    chk("stall_a_inst", out_inst, 32'h0010_0113);
    set_req(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_inst", out_inst, 32'h0010_0113);
      chk("stall_addr", out_addr, 32'h1c);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("b_inst", out_inst, 32'h0020_0193);
    chk("b_addr", out_addr, 32'h20);
    set_req(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd3);
    step();
    in_valid = 1'b0;
    chk("c_inst", out_inst, 32'h0030_0213);
    chk("c_addr", out_addr, 32'h24);
    step();
    chk("stream_cnt", {16'd0, inst_cnt}, 32'd10);
    chk("stream_idle", {31'd0, out_valid}, 32'd0);

    // Async reset with a word pending
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_cnt", {16'd0, inst_cnt}, 32'd0);
    chk("arst_err", {16'd0, err_cnt}, 32'd0);
    chk("arst_addr", out_addr, 32'h0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Build up state, then restart with a concurrent request
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    chk("post_rst_addr", out_addr, 32'h0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd1);
    chk("pre_restart_sticky", {31'd0, err_sticky}, 32'd1);
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1);
    chk("pending_addr", out_addr, 32'h4);
    out_ready = 1'b1;
    restart = 1'b1;
    set_req(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd2);
    #1;
    chk("restart_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    restart = 1'b0;
    in_valid = 1'b0;
    chk("restart_valid", {31'd0, out_valid}, 32'd0);
    chk("restart_cnt", {16'd0, inst_cnt}, 32'd0);
    chk("restart_err", {16'd0, err_cnt}, 32'd0);
    chk("restart_sticky", {31'd0, err_sticky}, 32'd0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    chk("after_restart_inst", out_inst, 32'h1234_52b7);
    chk("after_restart_addr", out_addr, 32'h0);
    step();
    chk("after_restart_cnt", {16'd0, inst_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
